step_pulse_receiver: RTL

Receive end of the step-pulse interface. The block accepts a raw, asynchronous step line from the sensor or the external pulse source and synchronizes and debounces it. It emits one clean single-cycle step strobe per accepted rising edge, and it measures steps per one-second window with the 32/64 steps-per-second activity flags. It sits in front of the step counter, distance and activity blocks, replacing an ideal internal pulse generator when real hardware drives steps.

---
 rtl/step_pulse_receiver_if.sv | 20 ++
 rtl/step_pulse_receiver.sv | 90 +++++++++
 2 files changed

// File: rtl/step_pulse_receiver_if.sv
// Step-pulse link between a raw step source and its receiver: the raw line in,
// the clean strobe and the per-window rate results out.
interface step_pulse_receiver_if;
   logic       STEP_IN;
   logic       STEP_STROBE;
   logic [7:0] RATE;
   logic       RATE_VALID;
   logic       OVER32;
   logic       HIGH64;

   modport master (
      output STEP_IN,
      input  STEP_STROBE, RATE, RATE_VALID, OVER32, HIGH64
   );

   modport slave (
      input  STEP_IN,
      output STEP_STROBE, RATE, RATE_VALID, OVER32, HIGH64
   );
endinterface

// File: rtl/step_pulse_receiver.sv
// Synchronizes and debounces a raw step line, emits one strobe per accepted
// rising edge, and reports steps per window with 32/64 activity flags.
module step_pulse_receiver #(
   parameter int unsigned DEBOUNCE_CYCLES = 100000,
   parameter int unsigned WINDOW_CYCLES   = 100000000
) (
   input logic                  CLK,
   input logic                  RESET,
   step_pulse_receiver_if.slave bus
);
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned WW = $clog2(WINDOW_CYCLES);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WW-1:0] W_LAST = WW'(WINDOW_CYCLES - 1);

   logic          s1, s2;
   logic          db;
   logic [DW-1:0] dcnt;
   logic [WW-1:0] wcnt;
   logic [7:0]    acc;
   logic          step_strobe;
   logic [7:0]    rate;
   logic          rate_valid;
   logic          over32, high64;

   logic          promote;
   logic          terminal;
   logic [7:0]    acc_inc;
   logic [7:0]    closing_rate;

   assign promote      = (s2 != db) && (dcnt == D_LAST);
   assign terminal     = (wcnt == W_LAST);
   assign acc_inc      = (acc == 8'hFF) ? acc : acc + 8'd1;
   // A strobe visible during the terminal cycle belongs to the closing window.
   assign closing_rate = step_strobe ? acc_inc : acc;

   // NOTE: non-blocking assignments here so every flop samples pre-edge values;
   // s2 <= s1 then forms a true two-stage synchronizer, not a single wire.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         db          <= 1'b0;
         dcnt        <= '0;
         wcnt        <= '0;
         acc         <= '0;
         step_strobe <= 1'b0;
         rate        <= '0;
         rate_valid  <= 1'b0;
         over32      <= 1'b0;
         high64      <= 1'b0;
      end else begin
         s1 <= bus.STEP_IN;
         s2 <= s1;

         // Any sample matching the stable level restarts the stability count.
         if (s2 == db) begin
            dcnt <= '0;
         end else if (promote) begin
            db   <= s2;
            dcnt <= '0;
         end else begin
            dcnt <= dcnt + 1'b1;
         end

         step_strobe <= promote & s2;

         if (terminal) begin
            wcnt       <= '0;
            acc        <= '0;
            rate       <= closing_rate;
            rate_valid <= 1'b1;
            over32     <= (closing_rate > 8'd32);
            high64     <= (closing_rate >= 8'd64);
         end else begin
            wcnt       <= wcnt + 1'b1;
            rate_valid <= 1'b0;
            if (step_strobe) begin
               acc <= acc_inc;
            end
         end
      end
   end

   assign bus.STEP_STROBE = step_strobe;
   assign bus.RATE        = rate;
   assign bus.RATE_VALID  = rate_valid;
   assign bus.OVER32      = over32;
   assign bus.HIGH64      = high64;
endmodule
